// File: rtl/calc_ctrl_seq.sv
// calc_ctrl_seq: control unit and operand-entry sequencer for the WIDTH-bit
// keypad calculator. Builds operands A and B from one-cycle key strobes,
// latches the operator, launches a multi-cycle ALU operation and captures its
// result with overflow and timeout error handling.
//
// Optional feature: define CALC_CHAIN_EN to let an operator key in the done
// state reuse the result as operand A (chained operations). Without it,
// operator keys in the done state are ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   clearAll     in   synchronous active-high reset, highest priority
//   key          in   4-bit key code, 0-9 are digits
//   key_valid    in   one-cycle strobe qualifying key
//   alu_done     in   ALU completion pulse
//   alu_ovf      in   ALU overflow, valid with alu_done
//   alu_result   in   ALU result, valid with alu_done
//   opA, opB     out  operand registers
//   op_sel       out  00 add, 01 sub, 10 mul, 11 and
//   alu_start    out  one-cycle ALU launch pulse
//   loadR        out  one-cycle result-load pulse
//   result       out  captured result
//   result_valid out  result available (done state)
//   busy         out  ALU operation in flight
//   err          out  overflow or timeout error
module calc_ctrl_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [3:0]  KEY_ADD   = 4'hA,
  parameter logic [3:0]  KEY_SUB   = 4'hB,
  parameter logic [3:0]  KEY_MUL   = 4'hC,
  parameter logic [3:0]  KEY_AND   = 4'hD,
  parameter logic [3:0]  KEY_CLR   = 4'hE,
  parameter logic [3:0]  KEY_ENTER = 4'hF
) (
  input  logic             clk,
  input  logic             clearAll,
  input  logic [3:0]       key,
  input  logic             key_valid,
  input  logic             alu_done,
  input  logic             alu_ovf,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic [1:0]       op_sel,
  output logic             alu_start,
  output logic             loadR,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned NDIG    = WIDTH / 4;
  localparam int unsigned DCW     = $clog2(NDIG + 1);
  localparam int unsigned TCW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [DCW-1:0]   cnta_q, cnta_d;
  logic [DCW-1:0]   cntb_q, cntb_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic             start_q, start_d;
  logic             load_q, load_d;
  logic             rv_q, rv_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // Key decode, qualified by the strobe.
  logic       is_digit_c, is_op_c, is_clr_c, is_enter_c;
  logic [1:0] key_op_c;

  always_comb begin
    is_digit_c = 1'b0;
    is_op_c    = 1'b0;
    is_clr_c   = 1'b0;
    is_enter_c = 1'b0;
    key_op_c   = 2'b00;
    if (key_valid) begin
      if (key <= 4'd9) begin
        is_digit_c = 1'b1;
      end else if (key == KEY_ADD) begin
        is_op_c  = 1'b1;
        key_op_c = 2'b00;
      end else if (key == KEY_SUB) begin
        is_op_c  = 1'b1;
        key_op_c = 2'b01;
      end else if (key == KEY_MUL) begin
        is_op_c  = 1'b1;
        key_op_c = 2'b10;
      end else if (key == KEY_AND) begin
        is_op_c  = 1'b1;
        key_op_c = 2'b11;
      end else if (key == KEY_CLR) begin
        is_clr_c = 1'b1;
      end else if (key == KEY_ENTER) begin
        is_enter_c = 1'b1;
      end
    end
  end

  // Timeout fires on the last permitted WAIT cycle unless alu_done wins.
  logic to_last_c;
  assign to_last_c = (TIMEOUT != 0) && (tmo_q == TCW'(TO_LAST));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    op_d    = op_q;
    cnta_d  = cnta_q;
    cntb_d  = cntb_q;
    tmo_d   = '0;
    load_d  = 1'b0;

    case (state_q)
      S_A: begin
        if (is_digit_c) begin
          if (cnta_q < DCW'(NDIG)) begin
            opa_d  = {opa_q[WIDTH-5:0], key};
            cnta_d = cnta_q + DCW'(1);
          end
        end else if (is_op_c) begin
          op_d    = key_op_c;
          opb_d   = '0;
          cntb_d  = '0;
          state_d = S_B;
        end else if (is_clr_c) begin
          opa_d  = '0;
          cnta_d = '0;
        end
      end

      S_B: begin
        if (is_digit_c) begin
          if (cntb_q < DCW'(NDIG)) begin
            opb_d  = {opb_q[WIDTH-5:0], key};
            cntb_d = cntb_q + DCW'(1);
          end
        end else if (is_op_c) begin
          // Operator can be changed only until the first B digit.
          if (cntb_q == '0) begin
            op_d = key_op_c;
          end
        end else if (is_clr_c) begin
          opb_d  = '0;
          cntb_d = '0;
        end else if (is_enter_c && (cntb_q != '0)) begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (alu_done) begin
          res_d   = alu_result;
          load_d  = 1'b1;
          state_d = alu_ovf ? S_ERR : S_DONE;
        end else if (to_last_c) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end

      S_DONE: begin
        if (is_digit_c) begin
          // The restarting digit is the first digit of the new operand A.
          opa_d   = {{(WIDTH-4){1'b0}}, key};
          cnta_d  = DCW'(1);
          opb_d   = '0;
          cntb_d  = '0;
          state_d = S_A;
        end else if (is_clr_c) begin
          opa_d   = '0;
          opb_d   = '0;
          cnta_d  = '0;
          cntb_d  = '0;
          state_d = S_A;
        end else if (is_op_c) begin
`ifdef CALC_CHAIN_EN
          opa_d   = res_q;
          cnta_d  = '0;
          opb_d   = '0;
          cntb_d  = '0;
          op_d    = key_op_c;
          state_d = S_B;
`else
          state_d = S_DONE;
`endif
        end
      end

      S_ERR: begin
        if (is_clr_c) begin
          opa_d   = '0;
          opb_d   = '0;
          res_d   = '0;
          op_d    = 2'b00;
          cnta_d  = '0;
          cntb_d  = '0;
          state_d = S_A;
        end
      end

      default: begin
        state_d = S_A;
      end
    endcase

    // Status flags are registered copies of the next state's decode.
    start_d = (state_d == S_EXEC);
    busy_d  = (state_d == S_EXEC) || (state_d == S_WAIT);
    rv_d    = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  // State and datapath registers; clearAll overrides everything.
  always_ff @(posedge clk) begin
    if (clearAll) begin
      state_q <= S_A;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      op_q    <= 2'b00;
      cnta_q  <= '0;
      cntb_q  <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      load_q  <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnta_q  <= cnta_d;
      cntb_q  <= cntb_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      load_q  <= load_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign opA          = opa_q;
  assign opB          = opb_q;
  assign op_sel       = op_q;
  assign alu_start    = start_q;
  assign loadR        = load_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
